spi_shift_engine: RTL and testbench

SPI mode-0 byte transceiver that sits directly downstream of the SPI clock divider. It accepts one byte from the host over a valid/ready handshake and asserts chip select. It then launches the divider's 8-clock burst, shifts MOSI out on the divider's falling-edge markers and samples MISO on its rising-edge markers. Finally it returns the received byte with a one-cycle valid pulse.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_shift_engine_if.sv | 21 ++
 rtl/spi_shift_reg.sv | 36 +++
 rtl/spi_shift_engine.sv | 116 +++++++++++
 tb/tb_spi_shift_engine.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI shift engine.
//   SPI_WORD_BITS : burst length, matches the upstream clock divider
//   BIT_CNT_W     : width of the received-bit counter
//   ST_*          : one-hot FSM state encodings
package spi_pkg;
  localparam int SPI_WORD_BITS = 8;
  localparam int BIT_CNT_W     = 4;

  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_SETUP = 5'b00010;
  localparam logic [4:0] ST_START = 5'b00100;
  localparam logic [4:0] ST_SHIFT = 5'b01000;
  localparam logic [4:0] ST_DONE  = 5'b10000;
endpackage

// File: rtl/spi_shift_engine_if.sv
// spi_shift_engine_if: host-side byte handshake of the SPI shift engine.
//   i_tx_byte/i_tx_valid/o_tx_ready : TX byte valid/ready handshake
//   i_cs_hold                       : keep CS_n low after this byte
//   o_rx_byte/o_rx_valid            : received byte + one-cycle strobe
//   o_err                           : one-cycle strobe on a short burst
// master = host side, slave = engine side.
interface spi_shift_engine_if;
  import spi_pkg::*;
  logic [SPI_WORD_BITS-1:0] i_tx_byte;
  logic                     i_tx_valid;
  logic                     o_tx_ready;
  logic                     i_cs_hold;
  logic [SPI_WORD_BITS-1:0] o_rx_byte;
  logic                     o_rx_valid;
  logic                     o_err;

  modport master (output i_tx_byte, i_tx_valid, i_cs_hold,
                  input  o_tx_ready, o_rx_byte, o_rx_valid, o_err);
  modport slave  (input  i_tx_byte, i_tx_valid, i_cs_hold,
                  output o_tx_ready, o_rx_byte, o_rx_valid, o_err);
endinterface

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: parallel-load shift register, zero-fill on shift_out.
//   i_load/i_load_val : parallel load (highest priority)
//   i_shift_in        : shift, inserting i_ser_in
//   i_shift_out       : shift, inserting 0
//   o_ser_out         : bit currently on the serial output
//   o_q               : register contents
// LSB_FIRST selects shift direction (right when set, left otherwise).
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_load,
  input  logic [SPI_WORD_BITS-1:0] i_load_val,
  input  logic                     i_shift_out,
  input  logic                     i_shift_in,
  input  logic                     i_ser_in,
  output logic                     o_ser_out,
  output logic [SPI_WORD_BITS-1:0] o_q
);
  localparam int W = SPI_WORD_BITS;

  logic [W-1:0] q;

  always_ff @(posedge i_clk) begin
    if (i_rst)            q <= '0;
    else if (i_load)      q <= i_load_val;
    else if (i_shift_in)  q <= LSB_FIRST ? {i_ser_in, q[W-1:1]} : {q[W-2:0], i_ser_in};
    else if (i_shift_out) q <= LSB_FIRST ? {1'b0, q[W-1:1]}     : {q[W-2:0], 1'b0};
  end

  assign o_ser_out = LSB_FIRST ? q[0] : q[W-1];
  assign o_q       = q;
endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI mode-0 byte transceiver behind the SPI clock divider.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   host (slave modport)  : byte handshake, CS hold, RX byte/valid, error
//   o_div_start_n         : divider burst request (active low)
//   i_div_ready/_sclk     : divider status and slow clock
//   i_div_rising/_falling : divider edge markers
//   o_sclk/o_mosi/i_miso/o_cs_n : SPI pins
// Build option: define SPI_LSB_FIRST_EN for LSB-first shifting on both
// MOSI and MISO; default is MSB-first.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int CS_SETUP_CYCLES = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  spi_shift_engine_if.slave   host,
  output logic                o_div_start_n,
  input  logic                i_div_ready,
  input  logic                i_div_sclk,
  input  logic                i_div_rising,
  input  logic                i_div_falling,
  output logic                o_sclk,
  output logic                o_mosi,
  input  logic                i_miso,
  output logic                o_cs_n
);
`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  logic [4:0]                 state;
  logic [3:0]                 setup_cnt;
  logic [BIT_CNT_W-1:0]       bit_cnt;
  logic                       cs_hold_q;
  logic                       cs_n_q;
  logic [SPI_WORD_BITS-1:0]   rx_hold;
  logic [SPI_WORD_BITS-1:0]   rx_q;
  logic [SPI_WORD_BITS-1:0]   tx_q;
  logic                       tx_ser;
  logic                       rx_ser;
  logic                       accept, rise_en, fall_en, cnt_full, in_done;

  assign accept   = host.i_tx_valid & host.o_tx_ready;
  // Simultaneous markers are illegal; the rising one wins.
  assign rise_en  = (state == ST_SHIFT) & i_div_rising;
  assign fall_en  = (state == ST_SHIFT) & i_div_falling & ~i_div_rising;
  assign cnt_full = (bit_cnt == BIT_CNT_W'(SPI_WORD_BITS));
  assign in_done  = (state == ST_DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      setup_cnt <= '0;
      bit_cnt   <= '0;
      cs_hold_q <= 1'b0;
      cs_n_q    <= 1'b1;
      rx_hold   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          cs_hold_q <= host.i_cs_hold;
          bit_cnt   <= '0;
          setup_cnt <= '0;
          cs_n_q    <= 1'b0;
          state     <= ST_SETUP;
        end
        ST_SETUP: begin
          if (setup_cnt == 4'(CS_SETUP_CYCLES - 1)) state <= ST_START;
          else                                      setup_cnt <= setup_cnt + 4'd1;
        end
        // Hold the request until the divider acknowledges by dropping ready.
        ST_START: if (!i_div_ready) state <= ST_SHIFT;
        ST_SHIFT: begin
          if (rise_en && bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
          if (i_div_ready) state <= ST_DONE;
        end
        ST_DONE: begin
          if (cnt_full) rx_hold <= rx_q;
          cs_n_q <= ~cs_hold_q;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spi_shift_reg #(.LSB_FIRST(LSB_FIRST)) u_tx_sr (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_load(accept), .i_load_val(host.i_tx_byte),
    .i_shift_out(fall_en), .i_shift_in(1'b0), .i_ser_in(1'b0),
    .o_ser_out(tx_ser), .o_q(tx_q)
  );

  spi_shift_reg #(.LSB_FIRST(LSB_FIRST)) u_rx_sr (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_load(accept), .i_load_val('0),
    .i_shift_out(1'b0), .i_shift_in(rise_en), .i_ser_in(i_miso),
    .o_ser_out(rx_ser), .o_q(rx_q)
  );

  logic sr_unused;
  assign sr_unused = ^{rx_ser, tx_q};

  // RX byte is presented combinationally in DONE so it lines up with the strobe.
  assign host.o_tx_ready = (state == ST_IDLE) & i_div_ready;
  assign host.o_rx_valid = in_done & cnt_full;
  assign host.o_err      = in_done & ~cnt_full;
  assign host.o_rx_byte  = host.o_rx_valid ? rx_q : rx_hold;
  assign o_div_start_n   = ~(state == ST_START);
  assign o_sclk          = i_div_sclk;
  assign o_mosi          = tx_ser;
  assign o_cs_n          = cs_n_q;
endmodule

// File: tb/tb_spi_shift_engine.sv
module tb_spi_shift_engine;
  localparam int CS = 2;
`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic div_start_n, div_ready, div_sclk, div_rising, div_falling;
  logic sclk, mosi, miso, cs_n;
  int   n_chk = 0;
  int   n_err = 0;
  logic cs_idle;

  spi_shift_engine_if host_if ();

  spi_shift_engine #(.CS_SETUP_CYCLES(CS)) dut (
    .i_clk(clk), .i_rst(rst), .host(host_if.slave),
    .o_div_start_n(div_start_n), .i_div_ready(div_ready),
    .i_div_sclk(div_sclk), .i_div_rising(div_rising), .i_div_falling(div_falling),
    .o_sclk(sclk), .o_mosi(mosi), .i_miso(miso), .o_cs_n(cs_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx, miso_b;
    logic       hold;
    int         nbits, gate;
    logic       exp_valid, exp_err;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic tx_bit(input logic [7:0] b, input int k);
    return LSB ? b[k] : b[7-k];
  endfunction

  // Accept a byte (optionally with ready held low for 'gate' cycles first),
  // then check CS timing and the setup delay up to the START request.
  task automatic do_accept(input logic [7:0] tx, input logic hold, input int gate);
    int cnt;
    host_if.i_tx_byte  = tx;
    host_if.i_cs_hold  = hold;
    host_if.i_tx_valid = 1'b1;
    for (int g = 0; g < gate; g++) begin
      div_ready = 1'b0;
      #1;
      chk("gate_tx_ready", host_if.o_tx_ready, 0);
      chk("gate_start_n", div_start_n, 1);
      chk("gate_cs_n", cs_n, cs_idle);
      @(posedge clk); #1;
    end
    div_ready = 1'b1;
    #1;
    chk("accept_tx_ready", host_if.o_tx_ready, 1);
    chk("accept_cs_n_before", cs_n, cs_idle);
    @(posedge clk); #1;
    host_if.i_tx_valid = 1'b0;
    host_if.i_tx_byte  = 8'h00;
    host_if.i_cs_hold  = 1'b0;
    #1;
    chk("cs_n_after_accept", cs_n, 0);
    chk("first_mosi", mosi, tx_bit(tx, 0));
    cnt = 0;
    while (div_start_n !== 1'b0 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("setup_delay", cnt, CS);
  endtask

  // Bit cycles 1-2: MISO set up, then rising marker (engine samples).
  task automatic half_bit(input logic mb, input logic exp_m);
    @(posedge clk); #1;
    div_sclk = 1'b0; div_falling = 1'b0; miso = mb;
    @(posedge clk); #1;
    div_sclk = 1'b1; div_rising = 1'b1;
    #1;
    chk("mosi_bit", mosi, exp_m);
    chk("sclk_pass", sclk, 1);
  endtask

  // Bit cycles 3-4: SCLK high, then falling marker (engine shifts).
  task automatic tail_bit();
    @(posedge clk); #1;
    div_rising = 1'b0;
    @(posedge clk); #1;
    div_sclk = 1'b0; div_falling = 1'b1;
  endtask

  task automatic do_burst(input logic [7:0] tx, input logic [7:0] mb, input int nbits);
    @(posedge clk); #1;
    div_ready = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      half_bit(tx_bit(mb, k), tx_bit(tx, k));
      tail_bit();
    end
    @(posedge clk); #1;
    div_falling = 1'b0; div_ready = 1'b1;
    #1;
    if (nbits == 8) chk("mosi_idle_after_burst", mosi, 0);
    chk("no_valid_before_done", host_if.o_rx_valid, 0);
  endtask

  task automatic do_done(input logic ev, input logic ee, input logic [7:0] erx, input logic ecs);
    @(posedge clk); #1;
    chk("done_rx_valid", host_if.o_rx_valid, ev);
    chk("done_err", host_if.o_err, ee);
    chk("done_rx_byte", host_if.o_rx_byte, erx);
    chk("done_cs_n", cs_n, 0);
    @(posedge clk); #1;
    chk("post_rx_valid", host_if.o_rx_valid, 0);
    chk("post_err", host_if.o_err, 0);
    chk("post_rx_byte", host_if.o_rx_byte, erx);
    chk("post_cs_n", cs_n, ecs);
    chk("post_tx_ready", host_if.o_tx_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'hA5, 8'h3C, 1'b0, 8, 0, 1'b1, 1'b0, 8'h3C};
    tbl[1] = '{8'hFF, 8'h5A, 1'b1, 8, 0, 1'b1, 1'b0, 8'h5A};
    tbl[2] = '{8'h00, 8'hC3, 1'b0, 8, 3, 1'b1, 1'b0, 8'hC3};
    tbl[3] = '{8'h12, 8'h77, 1'b0, 5, 0, 1'b0, 1'b1, 8'hC3};
    tbl[4] = '{8'h01, 8'h01, 1'b0, 8, 0, 1'b1, 1'b0, 8'h01};
    tbl[5] = '{8'h3C, 8'h81, 1'b1, 8, 2, 1'b1, 1'b0, 8'h81};

    host_if.i_tx_byte = 8'h00; host_if.i_tx_valid = 1'b0; host_if.i_cs_hold = 1'b0;
    div_ready = 1'b1; div_sclk = 1'b0; div_rising = 1'b0; div_falling = 1'b0; miso = 1'b0;
    cs_idle = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_rx_byte", host_if.o_rx_byte, 8'h00);
    chk("rst_rx_valid", host_if.o_rx_valid, 0);
    chk("rst_err", host_if.o_err, 0);
    chk("rst_start_n", div_start_n, 1);
    chk("rst_tx_ready_hi", host_if.o_tx_ready, 1);
    div_ready = 1'b0;
    #1;
    chk("rst_tx_ready_lo", host_if.o_tx_ready, 0);
    div_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_accept(tbl[i].tx, tbl[i].hold, tbl[i].gate);
      do_burst(tbl[i].tx, tbl[i].miso_b, tbl[i].nbits);
      do_done(tbl[i].exp_valid, tbl[i].exp_err, tbl[i].exp_rx, ~tbl[i].hold);
      cs_idle = ~tbl[i].hold;
    end

    // Reset after the third rising marker of a transfer.
    do_accept(8'hFF, 1'b1, 0);
    @(posedge clk); #1;
    div_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      half_bit(1'b1, 1'b1);
      if (k < 2) tail_bit();
    end
    @(posedge clk); #1;
    div_rising = 1'b0;
    rst = 1'b1;
    #1;
    chk("prerst_cs_n", cs_n, 0);
    chk("prerst_mosi", mosi, 1);
    @(posedge clk); #1;
    chk("midrst_cs_n", cs_n, 1);
    chk("midrst_mosi", mosi, 0);
    chk("midrst_rx_valid", host_if.o_rx_valid, 0);
    chk("midrst_err", host_if.o_err, 0);
    chk("midrst_start_n", div_start_n, 1);
    chk("midrst_rx_byte", host_if.o_rx_byte, 8'h00);
    rst = 1'b0; div_sclk = 1'b0; div_ready = 1'b1;
    #1;
    chk("midrst_idle", host_if.o_tx_ready, 1);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("postrst_rx_valid", host_if.o_rx_valid, 0);
      chk("postrst_err", host_if.o_err, 0);
      chk("postrst_cs_n", cs_n, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
